// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and the fixed requester slots used by the processor and chain forwarder.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int REQ_LOCAL = 0;
    localparam int REQ_CHAIN = 1;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first valid requester found
// after the previous grant, wrapping modulo NREQ.
module uart_tx_arbiter_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  grant_id,
    output logic [IDW-1:0]  next_id,
    output logic            any_valid
);

    logic [IDW-1:0] idx;

    always_comb begin
        next_id   = grant_id;
        any_valid = |req_valid;
        idx       = '0;
        // Farthest offset first so the nearest valid requester overwrites it.
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(grant_id) + k) % NREQ);
            if (req_valid[idx]) begin
                next_id = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter between NREQ
// byte-stream requesters, with a watchdog that reclaims a stalled grant.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024,
    parameter int GUARD   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     txBusy,
    output logic                     txStart,
    output logic [BYTE_W-1:0]        txData,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     locked,
    output logic [7:0]               timeout_count
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GUARD + 2);

    logic [1:0]        state_q, state_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic              locked_q, locked_d;
    logic              tx_start_q, tx_start_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              last_q, last_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic [GW-1:0]     guard_q, guard_d;
    logic [7:0]        timeout_count_q, timeout_count_d;

    logic [IDW-1:0]    next_id;
    logic              any_valid;
    logic              sel_valid;
    logic              sel_last;
    logic [BYTE_W-1:0] sel_byte;

    uart_tx_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .grant_id  (grant_id_q),
        .next_id   (next_id),
        .any_valid (any_valid)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_byte  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_SEND) begin
            req_ready[grant_id_q] = !txBusy;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_id_d      = grant_id_q;
        locked_d        = locked_q;
        tx_start_d      = 1'b0;
        tx_data_d       = tx_data_q;
        last_d          = last_q;
        wd_d            = wd_q;
        guard_d         = guard_q;
        timeout_count_d = timeout_count_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    grant_id_d = next_id;
                    locked_d   = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // A busy transmitter freezes both the handshake and the watchdog.
                if (!txBusy) begin
                    if (sel_valid) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = sel_byte;
                        last_d     = sel_last;
                        wd_d       = '0;
                        guard_d    = '0;
                        state_d    = ST_HOLD;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        wd_d     = '0;
                        locked_d = 1'b0;
                        state_d  = ST_IDLE;
                        if (timeout_count_q != 8'hFF) begin
                            timeout_count_d = timeout_count_q + 8'd1;
                        end
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (guard_q == GW'(GUARD)) begin
                    if (last_q) begin
                        locked_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            grant_id_q      <= IDW'(NREQ - 1);
            locked_q        <= 1'b0;
            tx_start_q      <= 1'b0;
            tx_data_q       <= '0;
            last_q          <= 1'b0;
            wd_q            <= '0;
            guard_q         <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            grant_id_q      <= grant_id_d;
            locked_q        <= locked_d;
            tx_start_q      <= tx_start_d;
            tx_data_q       <= tx_data_d;
            last_q          <= last_d;
            wd_q            <= wd_d;
            guard_q         <= guard_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign txStart       = tx_start_q;
    assign txData        = tx_data_q;
    assign grant_id      = grant_id_q;
    assign locked        = locked_q;
    assign timeout_count = timeout_count_q;

endmodule
